// File: rtl/quad_enc_pkg.sv
// rtl/quad_enc_pkg.sv - Shared types and constants for the quadrature encoder decoder
//
// Holds the FSM state encodings (state value equals the accepted {A,B}
// pair), the position width and the parameter defaults used by
// quad_encoder_decoder and enc_debounce.
package quad_enc_pkg;

    localparam int POS_W                   = 5;
    localparam int MAX_POS_DEFAULT         = 20;
    localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

    // Encoding is the {A,B} pair itself, so the next state is simply the
    // newly accepted pair and no decode table is needed.
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } enc_state_t;

    // Both channels changed between two accepted samples: the direction
    // cannot be known, so the transition is treated as illegal.
    function automatic logic is_two_bit_change(input logic [1:0] from_ab,
                                               input logic [1:0] to_ab);
        return (from_ab ^ to_ab) == 2'b11;
    endfunction

endpackage

// File: rtl/enc_debounce.sv
// rtl/enc_debounce.sv - One-channel 2-flop synchronizer plus debounce filter
//
// Purpose: brings one asynchronous encoder channel into the clk domain and,
// when enabled, only accepts a new level after it has been seen for
// DEBOUNCE_CYCLES consecutive cycles.
//
// Configuration macro: QUAD_ENC_DEBOUNCE_EN
//   defined   -> synchronizer followed by the debounce counter
//   undefined -> synchronizer output drives clean directly
//
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset
//   raw    in   asynchronous channel input
//   clean  out  synchronized (and optionally debounced) level
module enc_debounce
    import quad_enc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean
);

    logic [1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw};
        end
    end

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

`ifdef QUAD_ENC_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             stable_q;

    // The count tracks how many consecutive cycles the synchronized input
    // has disagreed with the accepted level. Any agreeing cycle restarts
    // it, so a short glitch never accumulates towards acceptance. The
    // update fires on the cycle that would make the run DEBOUNCE_CYCLES
    // long.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (sync_q[1] == stable_q) begin
            cnt_q    <= '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q    <= '0;
            stable_q <= sync_q[1];
        end else begin
            cnt_q    <= cnt_q + CNT_W'(1);
        end
    end

    assign clean = stable_q;
`else
    assign clean = sync_q[1];
`endif

endmodule

// File: rtl/quad_encoder_decoder.sv
// rtl/quad_encoder_decoder.sv - Quadrature encoder decoder with saturating position
//
// Purpose: decodes a mechanical quadrature encoder into a position 0..MAX_POS.
// One full clockwise detent (00->01->11->10->00) adds one, one full
// counter-clockwise detent subtracts one; only the return to 00 moves the
// position, so a shaft rocked inside a detent never drifts.
//
// Configuration macro: QUAD_ENC_DEBOUNCE_EN (debounce filters in front of
// the FSM; latency DEBOUNCE_CYCLES+3 edges, otherwise 3 edges).
//
// Ports:
//   clk     in   system clock
//   reset   in   synchronous active-high reset
//   enc_a   in   asynchronous channel A
//   enc_b   in   asynchronous channel B
//   Encout  out  registered position, 0..MAX_POS
//   step    out  one-cycle pulse on every cycle Encout changes
//   err     out  one-cycle pulse on a two-bit (illegal) transition
module quad_encoder_decoder
    import quad_enc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int MAX_POS         = MAX_POS_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    output logic [POS_W-1:0] Encout,
    output logic             step,
    output logic             err
);

    if (MAX_POS < 1 || MAX_POS > 31) begin : g_bad_max_pos
        $error("MAX_POS must be in 1..31");
    end

    localparam logic [POS_W-1:0] MAX_POS_V = POS_W'(MAX_POS);

    logic       a_clean;
    logic       b_clean;
    logic [1:0] ab;

    enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk   (clk),
        .reset (reset),
        .raw   (enc_a),
        .clean (a_clean)
    );

    enc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk   (clk),
        .reset (reset),
        .raw   (enc_b),
        .clean (b_clean)
    );

    assign ab = {a_clean, b_clean};

    enc_state_t state_q;
    enc_state_t state_d;
    logic       inc_req;
    logic       dec_req;
    logic       illegal;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S00;
        end else begin
            state_q <= state_d;
        end
    end

    // The state always follows the accepted pair; the interesting output is
    // which edge was crossed. Two-bit jumps still resynchronise the state so
    // the next legal move is judged from where the encoder really is.
    always_comb begin
        state_d = state_q;
        inc_req = 1'b0;
        dec_req = 1'b0;
        illegal = 1'b0;
        if (ab != state_q) begin
            state_d = enc_state_t'(ab);
            if (is_two_bit_change(state_q, ab)) begin
                illegal = 1'b1;
            end else begin
                case (state_q)
                    S10:     inc_req = (ab == 2'b00);
                    S01:     dec_req = (ab == 2'b00);
                    default: ;
                endcase
            end
        end
    end

    logic [POS_W-1:0] pos_d;

    // Saturating position: a request at a limit leaves the value alone,
    // and because step is derived from an actual change it stays low too.
    always_comb begin
        pos_d = Encout;
        if (inc_req && (Encout != MAX_POS_V)) begin
            pos_d = Encout + POS_W'(1);
        end else if (dec_req && (Encout != '0)) begin
            pos_d = Encout - POS_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Encout <= '0;
            step   <= 1'b0;
            err    <= 1'b0;
        end else begin
            Encout <= pos_d;
            step   <= (pos_d != Encout);
            err    <= illegal;
        end
    end

endmodule

// File: tb/tb_quad_encoder_decoder.sv
// tb/tb_quad_encoder_decoder.sv - Self-checking bench for quad_encoder_decoder
//
// Runs with DEBOUNCE_CYCLES=4, MAX_POS=20; expected latency and glitch
// behaviour follow QUAD_ENC_DEBOUNCE_EN.
`timescale 1ns/1ps
module tb_quad_encoder_decoder;

    localparam int D    = 4;
    localparam int MAXP = 20;
    localparam int HOLD = 10;
`ifdef QUAD_ENC_DEBOUNCE_EN
    localparam int LAT   = D + 3;
    localparam bit DB_ON = 1'b1;
`else
    localparam int LAT   = 3;
    localparam bit DB_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       enc_a;
    logic       enc_b;
    logic [4:0] Encout;
    logic       step;
    logic       err;

    quad_encoder_decoder #(.DEBOUNCE_CYCLES(D), .MAX_POS(MAXP)) dut (
        .clk    (clk),
        .reset  (reset),
        .enc_a  (enc_a),
        .enc_b  (enc_b),
        .Encout (Encout),
        .step   (step),
        .err    (err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int step_cnt = 0;
    int err_cnt  = 0;
    bit mon_on   = 1'b0;
    logic       rst_q = 1'b1;
    logic [4:0] prev_enc = '0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Pulse tally and the step/Encout relationship, sampled mid-cycle.
    always @(posedge clk) rst_q <= reset;
    always @(negedge clk) begin
        if (step === 1'b1) step_cnt++;
        if (err === 1'b1) err_cnt++;
        if (mon_on && !rst_q)
            check("step_tracks_encout", int'(step), int'(Encout != prev_enc));
        prev_enc = Encout;
    end

    // Behavioural reference: accepted AB pair and position.
    logic [1:0] m_state = 2'b00;
    int         m_pos   = 0;

    typedef struct {
        logic [1:0] ab;
        int         hold;
        int         exp_pos;
        int         exp_steps;
        int         exp_errs;
        string      name;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    function automatic void add_vec(input logic [1:0] ab, input string name);
        vec_t v;
        v.ab        = ab;
        v.hold      = HOLD;
        v.exp_steps = 0;
        v.exp_errs  = 0;
        v.name      = name;
        if (ab != m_state) begin
            if ((ab ^ m_state) == 2'b11) begin
                v.exp_errs = 1;
            end else if (m_state == 2'b10 && ab == 2'b00) begin
                if (m_pos < MAXP) begin m_pos++; v.exp_steps = 1; end
            end else if (m_state == 2'b01 && ab == 2'b00) begin
                if (m_pos > 0) begin m_pos--; v.exp_steps = 1; end
            end
            m_state = ab;
        end
        v.exp_pos = m_pos;
        vecs.push_back(v);
    endfunction

    function automatic void add_cw(input string name);
        add_vec(2'b01, name); add_vec(2'b11, name);
        add_vec(2'b10, name); add_vec(2'b00, name);
    endfunction

    function automatic void add_ccw(input string name);
        add_vec(2'b10, name); add_vec(2'b11, name);
        add_vec(2'b01, name); add_vec(2'b00, name);
    endfunction

    task automatic run_table();
        foreach (vecs[i]) begin
            int   s0;
            int   e0;
            vec_t got_v;
            enc_a = vecs[i].ab[1];
            enc_b = vecs[i].ab[0];
            sb.push_back(vecs[i]);
            s0 = step_cnt;
            e0 = err_cnt;
            tick(vecs[i].hold);
            got_v = sb.pop_front();
            check({got_v.name, "_pos"},   int'(Encout),  got_v.exp_pos);
            check({got_v.name, "_steps"}, step_cnt - s0, got_v.exp_steps);
            check({got_v.name, "_errs"},  err_cnt - e0,  got_v.exp_errs);
        end
        vecs.delete();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        enc_a = 1'b0;
        enc_b = 1'b0;
        tick(n);
        reset = 1'b0;
        m_state = 2'b00;
        m_pos   = 0;
        tick(LAT + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int e0;
        int first_edge;

        // Reset held with both channels high.
        reset = 1'b1;
        enc_a = 1'b1;
        enc_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("reset_encout", int'(Encout), 0);
            check("reset_step",   int'(step),   0);
            check("reset_err",    int'(err),    0);
        end
        enc_a = 1'b0;
        enc_b = 1'b0;
        reset = 1'b0;
        tick(LAT + 2);
        check("idle_encout", int'(Encout), 0);
        check("idle_errs",   err_cnt,      0);
        mon_on = 1'b1;

        // Clockwise detent with exact latency on the final change.
        add_vec(2'b01, "cw1_ab01");
        add_vec(2'b11, "cw1_ab11");
        add_vec(2'b10, "cw1_ab10");
        run_table();
        s0 = step_cnt;
        first_edge = -1;
        enc_a = 1'b0;
        enc_b = 1'b0;
        for (int i = 1; i <= HOLD; i++) begin
            tick(1);
            if (first_edge < 0 && Encout == 5'd1) begin
                first_edge = i;
                check("cw1_step_with_encout", int'(step), 1);
            end
        end
        check("cw1_latency_edges", first_edge, LAT);
        check("cw1_final_pos",     int'(Encout), 1);
        tick(1);
        check("cw1_step_pulses",   step_cnt - s0, 1);
        m_state = 2'b00;
        m_pos   = 1;

        // Saturation at both limits.
        do_reset(2);
        for (int i = 0; i < 3; i++) add_ccw("sat_ccw");
        for (int i = 0; i < 22; i++) add_cw("sat_cw");
        s0 = step_cnt;
        run_table();
        check("sat_final_pos",   int'(Encout),  20);
        check("sat_total_steps", step_cnt - s0, 20);

        // Two-cycle glitch on A from S00.
        do_reset(2);
        s0 = step_cnt;
        e0 = err_cnt;
        enc_a = 1'b1;
        tick(2);
        enc_a = 1'b0;
        tick(HOLD + 2);
        check("glitch_pos",   int'(Encout),  DB_ON ? 0 : 1);
        check("glitch_steps", step_cnt - s0, DB_ON ? 0 : 1);
        check("glitch_errs",  err_cnt - e0,  0);
        m_state = 2'b00;
        m_pos   = DB_ON ? 0 : 1;

        // Follow-up move proves the FSM still sits in S00.
        add_vec(2'b01, "post_glitch_ab01");
        add_vec(2'b00, "post_glitch_ab00");
        // Illegal two-bit jump from S00.
        add_vec(2'b11, "illegal_00_11");
        run_table();

        // Mid-detent reset from position 7.
        do_reset(2);
        for (int i = 0; i < 7; i++) add_cw("pre_rst_cw");
        add_vec(2'b01, "pre_rst_ab01");
        add_vec(2'b11, "pre_rst_ab11");
        run_table();
        check("pre_rst_pos", int'(Encout), 7);
        reset = 1'b1;
        enc_a = 1'b1;
        enc_b = 1'b0;
        s0 = step_cnt;
        tick(1);
        check("midrst_encout", int'(Encout), 0);
        check("midrst_step",   int'(step),   0);
        reset = 1'b0;
        e0 = err_cnt;
        tick(HOLD);
        check("midrst_steps", step_cnt - s0, 0);
        check("midrst_errs",  err_cnt - e0,  0);
        check("midrst_pos",   int'(Encout),  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
